// File: rtl/collision_scan.sv
// collision_scan: sequential multi-snake collision checker.
// On start, the snake bodies and lengths are snapshotted. One body segment
// (target t, index s) is visited per cycle and compared against every live
// head. Death flags accumulate and are published with a one-cycle done pulse.
// Optional arena bound check: define COLLISION_WALL_EN.
module collision_scan #(
  parameter int NUM_SNAKES = 2,
  parameter int MAX_LEN    = 16,
  parameter int NUM_LEN    = 10,
  parameter int LEN_BITS   = 5,
  parameter int X_MAX      = 32,
  parameter int Y_MAX      = 24
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [NUM_SNAKES*MAX_LEN*NUM_LEN-1:0] snakes,
  input  logic [NUM_SNAKES*LEN_BITS-1:0]        lens,
  output logic                                  busy,
  output logic                                  done,
  output logic [NUM_SNAKES-1:0]                 dead,
  output logic                                  head_on
);

  localparam int TW = (NUM_SNAKES > 1) ? $clog2(NUM_SNAKES) : 1;
  localparam int SW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`ifdef COLLISION_WALL_EN
  localparam bit WALL_EN = 1'b1;
`else
  localparam bit WALL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_next;

  logic [NUM_LEN-1:0]  body  [NUM_SNAKES][MAX_LEN];
  logic [LEN_BITS-1:0] len_q [NUM_SNAKES];
  logic [TW-1:0]       t;
  logic [LEN_BITS-1:0] s;
  logic [NUM_SNAKES-1:0] scratch, scratch_next;
  logic                  scratch_ho, scratch_ho_next;
  logic                  first, last;

  assign first = (t == '0) && (s == LEN_BITS'(1));
  assign last  = (t == TW'(NUM_SNAKES - 1)) && (s == LEN_BITS'(MAX_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Hits for the current (t, s) position, plus first-cycle head-on and wall checks
  always_comb begin
    scratch_next    = scratch;
    scratch_ho_next = scratch_ho;
    for (int unsigned h = 0; h < NUM_SNAKES; h++) begin
      if ((len_q[h] != '0) && (s < len_q[t]) && (body[h][0] == body[t][s[SW-1:0]]))
        scratch_next[h] = 1'b1;
    end
    if (first) begin
      for (int unsigned h = 0; h < NUM_SNAKES; h++) begin
        for (int unsigned g = 0; g < NUM_SNAKES; g++) begin
          if ((h != g) && (len_q[h] != '0) && (len_q[g] != '0) && (body[h][0] == body[g][0])) begin
            scratch_next[h] = 1'b1;
            scratch_ho_next = 1'b1;
          end
        end
        if (WALL_EN && (len_q[h] != '0) &&
            ((32'(body[h][0][NUM_LEN-1:NUM_LEN/2]) >= 32'(X_MAX)) ||
             (32'(body[h][0][NUM_LEN/2-1:0]) >= 32'(Y_MAX))))
          scratch_next[h] = 1'b1;
      end
    end
  end

  // Snapshot, scan counters, sticky scratch flags and published results
  always_ff @(posedge clk) begin
    if (rst) begin
      t          <= '0;
      s          <= LEN_BITS'(1);
      scratch    <= '0;
      scratch_ho <= 1'b0;
      dead       <= '0;
      head_on    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          for (int unsigned k = 0; k < NUM_SNAKES; k++) begin
            for (int unsigned i = 0; i < MAX_LEN; i++)
              body[k][i] <= snakes[(k*MAX_LEN + i)*NUM_LEN +: NUM_LEN];
            len_q[k] <= (lens[k*LEN_BITS +: LEN_BITS] > LEN_BITS'(MAX_LEN)) ?
                        LEN_BITS'(MAX_LEN) : lens[k*LEN_BITS +: LEN_BITS];
          end
          t          <= '0;
          s          <= LEN_BITS'(1);
          scratch    <= '0;
          scratch_ho <= 1'b0;
        end
        SCAN: begin
          scratch    <= scratch_next;
          scratch_ho <= scratch_ho_next;
          // Results are loaded on the edge into DONE so they are valid with the pulse
          if (last) begin
            dead    <= scratch_next;
            head_on <= scratch_ho_next;
          end else if (s == LEN_BITS'(MAX_LEN - 1)) begin
            s <= LEN_BITS'(1);
            t <= t + TW'(1);
          end else begin
            s <= s + LEN_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scan.sv
// Directed self-checking bench for collision_scan at default parameters.
module tb_collision_scan;

  localparam int NS = 2;
  localparam int ML = 16;
  localparam int NL = 10;
  localparam int LB = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NS*ML*NL-1:0] snakes;
  logic [NS*LB-1:0]  lens;
  logic              busy;
  logic              done;
  logic [NS-1:0]     dead;
  logic              head_on;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  collision_scan #(
    .NUM_SNAKES(NS), .MAX_LEN(ML), .NUM_LEN(NL), .LEN_BITS(LB), .X_MAX(32), .Y_MAX(24)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .snakes(snakes), .lens(lens),
    .busy(busy), .done(done), .dead(dead), .head_on(head_on)
  );

  task automatic set_seg(input int k, input int i, input int x, input int y);
    snakes[(k*ML + i)*NL +: NL] = {5'(x), 5'(y)};
  endtask

  task automatic set_len(input int k, input int l);
    lens[k*LB +: LB] = LB'(l);
  endtask

  // Unused segments get unique coordinates no test head ever uses
  task automatic set_base();
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < ML; i++) set_seg(k, i, 28 + k, i);
    set_seg(0, 0, 5, 5);   set_seg(0, 1, 5, 4);   set_seg(0, 2, 5, 3);   set_seg(0, 3, 5, 2);
    set_seg(1, 0, 20, 20); set_seg(1, 1, 20, 19); set_seg(1, 2, 20, 18); set_seg(1, 3, 20, 17);
    set_len(0, 4); set_len(1, 4);
  endtask

  // Pulse start from 1ns after an edge; returns busy in the cycle after acceptance
  task automatic launch(output logic b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b = busy;
  endtask

  // Counts edges until done is seen, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    logic b; int lat;
    rst = 1'b1; start = 1'b0; set_base();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (dead !== 2'b00) begin n_fail++; $display("FAIL reset_dead got %b want 00", dead); end
    n_checks++; if (head_on !== 1'b0) begin n_fail++; $display("FAIL reset_head_on got %b want 0", head_on); end
    rst = 1'b0;
    @(posedge clk); #1;
    b = 1'b0; lat = 0;
  endtask

  task automatic test_no_collision();
    logic b; int lat;
    set_base();
    launch(b);
    n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL t1_busy_after_start got %b want 1", b); end
    wait_done(lat);
    n_checks++; if (lat !== 30) begin n_fail++; $display("FAIL t1_latency got %0d want 30", lat); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_in_done got %b want 1", busy); end
    n_checks++; if (dead !== 2'b00) begin n_fail++; $display("FAIL t1_dead got %b want 00", dead); end
    n_checks++; if (head_on !== 1'b0) begin n_fail++; $display("FAIL t1_head_on got %b want 0", head_on); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL t1_done_pulse got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_after got %b want 0", busy); end
  endtask

  // s0 head on s1 segment 3; inputs changed mid-scan must not matter
  task automatic test_other_body();
    logic b; int lat;
    set_base(); set_seg(0, 0, 20, 17);
    launch(b);
    set_base();
    wait_done(lat);
    n_checks++; if (dead !== 2'b01) begin n_fail++; $display("FAIL t2_dead got %b want 01", dead); end
    n_checks++; if (head_on !== 1'b0) begin n_fail++; $display("FAIL t2_head_on got %b want 0", head_on); end
    @(posedge clk); #1;
    n_checks++; if (dead !== 2'b01) begin n_fail++; $display("FAIL t2_dead_hold got %b want 01", dead); end
  endtask

  task automatic test_self_and_stale();
    logic b; int lat;
    set_base(); set_seg(1, 2, 20, 20);
    launch(b); wait_done(lat);
    n_checks++; if (dead !== 2'b10) begin n_fail++; $display("FAIL t3_self got %b want 10", dead); end
    @(posedge clk); #1;
    set_len(1, 2);
    launch(b); wait_done(lat);
    n_checks++; if (dead !== 2'b00) begin n_fail++; $display("FAIL t3_stale got %b want 00", dead); end
    @(posedge clk); #1;
  endtask

  // Length above MAX_LEN clamps to 16, so segment 15 is live; at 15 it is stale
  task automatic test_clamp();
    logic b; int lat;
    set_base(); set_seg(1, 15, 20, 20); set_len(1, 31);
    launch(b); wait_done(lat);
    n_checks++; if (dead !== 2'b10) begin n_fail++; $display("FAIL clamp_len31 got %b want 10", dead); end
    @(posedge clk); #1;
    set_len(1, 15);
    launch(b); wait_done(lat);
    n_checks++; if (dead !== 2'b00) begin n_fail++; $display("FAIL clamp_len15 got %b want 00", dead); end
    @(posedge clk); #1;
  endtask

  task automatic set_head_on();
    set_base();
    set_seg(0, 0, 7, 7); set_seg(0, 1, 7, 6); set_seg(0, 2, 7, 5);
    set_seg(1, 0, 7, 7); set_seg(1, 1, 8, 7); set_seg(1, 2, 9, 7);
    set_len(0, 3); set_len(1, 3);
  endtask

  task automatic test_head_on();
    logic b; int lat;
    set_head_on();
    launch(b); wait_done(lat);
    n_checks++; if (dead !== 2'b11) begin n_fail++; $display("FAIL t4_dead got %b want 11", dead); end
    n_checks++; if (head_on !== 1'b1) begin n_fail++; $display("FAIL t4_head_on got %b want 1", head_on); end
    @(posedge clk); #1;
  endtask

  task automatic test_absent_and_ignored_start();
    logic b; int lat; int ndone; logic [1:0] seen;
    set_base(); set_len(0, 0); set_seg(0, 0, 20, 19);
    launch(b);
    ndone = 0; seen = 2'bxx;
    for (int c = 0; c < 45; c++) begin
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (done) begin ndone++; seen = dead; end
      @(posedge clk); #1;
    end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL t5_done_count got %0d want 1", ndone); end
    n_checks++; if (seen !== 2'b00) begin n_fail++; $display("FAIL t5_dead got %b want 00", seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_idle got %b want 0", busy); end
    lat = 0;
  endtask

  task automatic test_reset_mid_scan();
    logic b; int lat; int ndone;
    set_head_on();
    launch(b);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy got %b want 0", busy); end
    n_checks++; if (dead !== 2'b00) begin n_fail++; $display("FAIL t6_dead got %b want 00", dead); end
    n_checks++; if (head_on !== 1'b0) begin n_fail++; $display("FAIL t6_head_on got %b want 0", head_on); end
    ndone = 0;
    for (int c = 0; c < 35; c++) begin
      if (done || busy) ndone++;
      @(posedge clk); #1;
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL t6_no_done got %0d want 0", ndone); end
    launch(b); wait_done(lat);
    n_checks++; if (lat !== 30) begin n_fail++; $display("FAIL t6_latency got %0d want 30", lat); end
    n_checks++; if (dead !== 2'b11) begin n_fail++; $display("FAIL t6_dead_after got %b want 11", dead); end
    @(posedge clk); #1;
  endtask

  // start held from the done cycle: ignored in DONE, accepted the cycle after
  task automatic test_back_to_back();
    logic b; int lat;
    set_base(); set_seg(0, 0, 20, 17);
    launch(b); wait_done(lat);
    n_checks++; if (dead !== 2'b01) begin n_fail++; $display("FAIL b2b_first got %b want 01", dead); end
    set_base(); set_seg(1, 2, 20, 20);
    start = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got %b want 0", busy); end
    launch(b);
    n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", b); end
    wait_done(lat);
    n_checks++; if (lat !== 30) begin n_fail++; $display("FAIL b2b_latency got %0d want 30", lat); end
    n_checks++; if (dead !== 2'b10) begin n_fail++; $display("FAIL b2b_second got %b want 10", dead); end
    @(posedge clk); #1;
  endtask

`ifdef COLLISION_WALL_EN
  task automatic test_wall();
    logic b; int lat;
    set_base(); set_seg(0, 0, 5, 24);
    launch(b); wait_done(lat);
    n_checks++; if (dead !== 2'b01) begin n_fail++; $display("FAIL wall got %b want 01", dead); end
    n_checks++; if (lat !== 30) begin n_fail++; $display("FAIL wall_latency got %0d want 30", lat); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_no_collision();
    test_other_body();
    test_self_and_stale();
    test_clamp();
    test_head_on();
    test_absent_and_ignored_start();
    test_reset_mid_scan();
    test_back_to_back();
`ifdef COLLISION_WALL_EN
    test_wall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
